// File: rtl/plc_input_conditioner_pkg.sv
// Shared types and constants for the lathe PLC input front-end.
package plc_pkg;

  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_AUTO = 2'b01,
    MODE_MAN  = 2'b10
  } mode_t;

  localparam int DEBOUNCE_SILICON = 500000;
  localparam int DEBOUNCE_SIM     = 4;

  // MAN wins over AUTO when both selectors are asserted.
  function automatic mode_t requested_mode(input logic auto_level, input logic man_level);
    mode_t result;
    result = MODE_NONE;
    if (man_level) begin
      result = MODE_MAN;
    end else if (auto_level) begin
      result = MODE_AUTO;
    end
    return result;
  endfunction

endpackage

// File: rtl/plc_input_conditioner_if.sv
// Panel inputs and conditioned outputs shared between the front-end and the PLC core.
interface plc_input_conditioner_if;
  import plc_pkg::*;

  logic  ena;
  logic  start_raw;
  logic  auto_raw;
  logic  man_raw;
  logic  start_level;
  logic  start_rise;
  logic  start_fall;
  mode_t mode;
  logic  mode_change;
  logic  mode_blocked;
  logic  conflict;

  modport master (
    output ena, start_raw, auto_raw, man_raw,
    input  start_level, start_rise, start_fall, mode, mode_change, mode_blocked, conflict
  );

  modport slave (
    input  ena, start_raw, auto_raw, man_raw,
    output start_level, start_rise, start_fall, mode, mode_change, mode_blocked, conflict
  );

endinterface

// File: rtl/plc_input_conditioner_debounce.sv
// One panel channel: 2-flop synchroniser, counting debouncer and registered edge pulses.
module plc_debounce #(
  parameter int DEBOUNCE_CYCLES = plc_pkg::DEBOUNCE_SILICON
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] count;

  // The counter only advances while sync2 disagrees with the stable bit and
  // is cleared on acceptance, so it never passes LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      count <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else if (ena) begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == level) begin
        count <= '0;
      end else if (count == LAST) begin
        level <= sync2;
        count <= '0;
        rise  <= sync2;
        fall  <= ~sync2;
      end else begin
        count <= count + CW'(1);
      end
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
    end
  end

endmodule

// File: rtl/plc_input_conditioner.sv
// Panel front-end top: three debounced channels, mode FSM with start interlock, conflict flag.
module plc_input_conditioner
  import plc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SILICON
) (
  input logic                    clk,
  input logic                    rst,
  plc_input_conditioner_if.slave bus
);

  logic       auto_level;
  logic       man_level;
  logic [3:0] edges_unused;

  mode_t mode_q;
  mode_t mode_next;
  mode_t requested;
  logic  change_next;
  logic  blocked_next;
  logic  mode_change_q;
  logic  mode_blocked_q;
  logic  conflict_q;

  plc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk   (clk),
    .rst   (rst),
    .ena   (bus.ena),
    .raw   (bus.start_raw),
    .level (bus.start_level),
    .rise  (bus.start_rise),
    .fall  (bus.start_fall)
  );

  plc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_auto (
    .clk   (clk),
    .rst   (rst),
    .ena   (bus.ena),
    .raw   (bus.auto_raw),
    .level (auto_level),
    .rise  (edges_unused[0]),
    .fall  (edges_unused[1])
  );

  plc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_man (
    .clk   (clk),
    .rst   (rst),
    .ena   (bus.ena),
    .raw   (bus.man_raw),
    .level (man_level),
    .rise  (edges_unused[2]),
    .fall  (edges_unused[3])
  );

  // Changes wait while START is held; the registered start_level means a
  // pending request lands one edge after the release is seen.
  always_comb begin
    requested    = requested_mode(auto_level, man_level);
    mode_next    = mode_q;
    change_next  = 1'b0;
    blocked_next = (requested != mode_q) && bus.start_level;
    if ((requested != mode_q) && !bus.start_level) begin
      mode_next   = requested;
      change_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q         <= MODE_NONE;
      mode_change_q  <= 1'b0;
      mode_blocked_q <= 1'b0;
      conflict_q     <= 1'b0;
    end else if (bus.ena) begin
      mode_q         <= mode_next;
      mode_change_q  <= change_next;
      mode_blocked_q <= blocked_next;
      conflict_q     <= auto_level & man_level;
    end else begin
      mode_change_q  <= 1'b0;
    end
  end

  assign bus.mode         = mode_q;
  assign bus.mode_change  = mode_change_q;
  assign bus.mode_blocked = mode_blocked_q;
  assign bus.conflict     = conflict_q;

endmodule
